// File: rtl/fetch_queue.sv
// Instruction fetch queue between IF and the if2id register: decouples fetch
// from decode stalls, with optional same-cycle bypass and two flush flavours.
module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int EXC_W  = 8,
  parameter int BYPASS = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush_i,
  input  logic                           redirect_i,
  input  logic                           push_valid_i,
  output logic                           push_ready_o,
  input  logic [ADDR_W-1:0]              push_pc_i,
  input  logic [DATA_W-1:0]              push_instr_i,
  input  logic [EXC_W-1:0]               push_except_i,
  output logic                           pop_valid_o,
  input  logic                           pop_ready_i,
  output logic [ADDR_W-1:0]              pop_pc_o,
  output logic [DATA_W-1:0]              pop_instr_o,
  output logic [EXC_W-1:0]               pop_except_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] pc_mem     [DEPTH];
  logic [DATA_W-1:0] instr_mem  [DEPTH];
  logic [EXC_W-1:0]  except_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt, wr_ptr, wr_ptr_nxt, rd_adv;
  logic [CNT_W-1:0] count, count_nxt;

  logic empty, full, kill;
  logic push_fire, pop_fire, bypass_fire, write_en, stored_pop;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);
  assign kill  = flush_i | redirect_i;

  // rst gates the handshake so nothing is offered while the queue is held in reset
  assign push_ready_o = rst & ~full & ~kill;

  always_comb begin
    pop_valid_o = 1'b0;
    if (rst) begin
      if (!empty)
        pop_valid_o = 1'b1;
      else if (BYPASS != 0)
        pop_valid_o = push_valid_i & ~kill;
    end
  end

  assign push_fire   = push_valid_i & push_ready_o;
  assign pop_fire    = pop_valid_o & pop_ready_i;
  assign bypass_fire = (BYPASS != 0) & empty & pop_fire;
  assign write_en    = push_fire & ~bypass_fire;
  assign stored_pop  = pop_fire & ~empty;
  assign rd_adv      = rd_ptr + PTR_W'(stored_pop);

  // Bubbles present all-zero data: instr 0 decodes as a nop downstream.
  always_comb begin
    pop_pc_o     = '0;
    pop_instr_o  = '0;
    pop_except_o = '0;
    if (pop_valid_o) begin
      if (empty) begin
        pop_pc_o     = push_pc_i;
        pop_instr_o  = push_instr_i;
        pop_except_o = push_except_i;
      end else begin
        pop_pc_o     = pc_mem[rd_ptr];
        pop_instr_o  = instr_mem[rd_ptr];
        pop_except_o = except_mem[rd_ptr];
      end
    end
  end

  always_comb begin
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    count_nxt  = count;
    if (flush_i) begin
      count_nxt  = '0;
      rd_ptr_nxt = wr_ptr;
    end else if (redirect_i) begin
      // Keep only the new head (delay slot), if one survives this cycle's pop.
      rd_ptr_nxt = rd_adv;
      if (count > CNT_W'(stored_pop)) begin
        count_nxt  = CNT_W'(1);
        wr_ptr_nxt = rd_adv + PTR_W'(1);
      end else begin
        count_nxt = '0;
      end
    end else begin
      rd_ptr_nxt = rd_adv;
      if (write_en)
        wr_ptr_nxt = wr_ptr + PTR_W'(1);
      count_nxt = count + CNT_W'(write_en) - CNT_W'(stored_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      wr_ptr <= wr_ptr_nxt;
      count  <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (write_en) begin
      pc_mem[wr_ptr]     <= push_pc_i;
      instr_mem[wr_ptr]  <= push_instr_i;
      except_mem[wr_ptr] <= push_except_i;
    end
  end

  assign count_o = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed test-plan scenarios plus a queue scoreboard
// that tracks every push/pop/flush/redirect on the bypassing instance.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush_i = 1'b0, redirect_i = 1'b0;
  logic        push_valid_i = 1'b0, pop_ready_i = 1'b0;
  logic [31:0] push_pc_i = '0, push_instr_i = '0;
  logic [7:0]  push_except_i = '0;

  logic        push_ready_o, pop_valid_o;
  logic [31:0] pop_pc_o, pop_instr_o;
  logic [7:0]  pop_except_o;
  logic [2:0]  count_o;

  logic        nb_push_ready, nb_pop_valid;
  logic [31:0] nb_pop_pc, nb_pop_instr;
  logic [7:0]  nb_pop_except;
  logic [2:0]  nb_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .redirect_i(redirect_i),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
    .push_pc_i(push_pc_i), .push_instr_i(push_instr_i), .push_except_i(push_except_i),
    .pop_valid_o(pop_valid_o), .pop_ready_i(pop_ready_i),
    .pop_pc_o(pop_pc_o), .pop_instr_o(pop_instr_o), .pop_except_o(pop_except_o),
    .count_o(count_o)
  );

  fetch_queue #(.DEPTH(DEPTH), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .flush_i(flush_i), .redirect_i(redirect_i),
    .push_valid_i(push_valid_i), .push_ready_o(nb_push_ready),
    .push_pc_i(push_pc_i), .push_instr_i(push_instr_i), .push_except_i(push_except_i),
    .pop_valid_o(nb_pop_valid), .pop_ready_i(pop_ready_i),
    .pop_pc_o(nb_pop_pc), .pop_instr_o(nb_pop_instr), .pop_except_o(nb_pop_except),
    .count_o(nb_count)
  );

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    push_valid_i  = 1'b1;
    push_pc_i     = pc;
    push_instr_i  = instr;
    push_except_i = instr[7:0] ^ 8'h5A;
    step();
  endtask

  // Scoreboard for the bypassing instance: entries enter on push_fire, leave on pop_fire.
  logic [71:0] sb[$];
  logic [71:0] m_head;
  logic        m_ready, m_pv, m_pop, m_push;

  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
    end else begin
      m_ready = (sb.size() < DEPTH) && !flush_i && !redirect_i;
      m_pv    = (sb.size() != 0) || (push_valid_i && !flush_i && !redirect_i);
      m_head  = '0;
      if (m_pv)
        m_head = (sb.size() != 0) ? sb[0] : {push_pc_i, push_instr_i, push_except_i};
      check("mon_push_ready", 72'(push_ready_o), 72'(m_ready));
      check("mon_pop_valid", 72'(pop_valid_o), 72'(m_pv));
      check("mon_count", 72'(count_o), 72'(sb.size()));
      check("mon_head", {pop_pc_o, pop_instr_o, pop_except_o}, m_head);
      m_pop  = m_pv && pop_ready_i;
      m_push = push_valid_i && m_ready;
      if (flush_i) begin
        sb.delete();
      end else if (redirect_i) begin
        if (m_pop) void'(sb.pop_front());
        while (sb.size() > 1) void'(sb.pop_back());
      end else if (!(m_pop && sb.size() == 0)) begin
        if (m_pop) void'(sb.pop_front());
        if (m_push) sb.push_back({push_pc_i, push_instr_i, push_except_i});
      end
    end
  end

  logic [31:0] drain_exp [4];

  initial begin
    #3;
    check("reset_pop_valid", 72'(pop_valid_o), 72'(0));
    check("reset_count", 72'(count_o), 72'(0));
    check("reset_pop_instr", 72'({pop_pc_o, pop_instr_o}), 72'(0));
    rst = 1'b1;
    #1;
    check("reset_push_ready", 72'(push_ready_o), 72'(1));
    step();

    // ordering
    push(32'hBFC0_0000, 32'h11);
    check("order_count1", 72'(count_o), 72'(1));
    push(32'hBFC0_0004, 32'h22);
    check("order_count2", 72'(count_o), 72'(2));
    push(32'hBFC0_0008, 32'h33);
    check("order_count3", 72'(count_o), 72'(3));
    push_valid_i = 1'b0;
    pop_ready_i  = 1'b1;
    #1;
    check("order_pop0", 72'(pop_instr_o), 72'(32'h11));
    step();
    check("order_pop1", 72'(pop_instr_o), 72'(32'h22));
    step();
    check("order_pop2", 72'(pop_instr_o), 72'(32'h33));
    step();
    check("order_empty_count", 72'(count_o), 72'(0));
    check("order_empty_valid", 72'(pop_valid_o), 72'(0));
    pop_ready_i = 1'b0;

    // full boundary
    for (int i = 0; i < 4; i++) push(32'(i * 4), 32'hA0 + 32'(i));
    push_pc_i    = 32'h10;
    push_instr_i = 32'hA4;
    check("full_count", 72'(count_o), 72'(4));
    check("full_ready", 72'(push_ready_o), 72'(0));
    step();
    check("full_5th_not_stored", 72'(count_o), 72'(4));
    pop_ready_i = 1'b1;
    #1;
    check("full_ready_with_pop", 72'(push_ready_o), 72'(0));
    step();
    pop_ready_i = 1'b0;
    check("full_after_pop_count", 72'(count_o), 72'(3));
    check("full_after_pop_ready", 72'(push_ready_o), 72'(1));
    step();
    push_valid_i = 1'b0;
    check("full_5th_accepted", 72'(count_o), 72'(4));
    drain_exp = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
    pop_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("full_drain_order", 72'(pop_instr_o), 72'(drain_exp[i]));
      step();
    end
    check("full_drained", 72'(count_o), 72'(0));
    pop_ready_i = 1'b0;

    // bypass vs registered
    push_valid_i = 1'b1;
    push_pc_i    = 32'h80;
    push_instr_i = 32'hAA;
    pop_ready_i  = 1'b1;
    #1;
    check("bypass_valid", 72'(pop_valid_o), 72'(1));
    check("bypass_instr", 72'(pop_instr_o), 72'(32'hAA));
    check("nobypass_valid0", 72'(nb_pop_valid), 72'(0));
    step();
    push_valid_i = 1'b0;
    check("bypass_count", 72'(count_o), 72'(0));
    check("nobypass_valid1", 72'(nb_pop_valid), 72'(1));
    check("nobypass_instr", 72'(nb_pop_instr), 72'(32'hAA));
    step();
    check("nobypass_drained", 72'(nb_count), 72'(0));
    pop_ready_i = 1'b0;

    // redirect keeps delay slot
    push(32'h100, 32'hB0);
    push(32'h104, 32'hB1);
    push(32'h108, 32'hB2);
    push_valid_i = 1'b0;
    redirect_i   = 1'b1;
    pop_ready_i  = 1'b1;
    #1;
    check("redir_ready", 72'(push_ready_o), 72'(0));
    check("redir_head", 72'(pop_pc_o), 72'(32'h100));
    step();
    redirect_i  = 1'b0;
    pop_ready_i = 1'b0;
    check("redir_count", 72'(count_o), 72'(1));
    check("redir_slot", 72'(pop_pc_o), 72'(32'h104));
    push(32'h10C, 32'hB3);
    push_valid_i = 1'b0;
    check("redir_push_count", 72'(count_o), 72'(2));
    pop_ready_i = 1'b1;
    #1;
    check("redir_pop_slot", 72'(pop_pc_o), 72'(32'h104));
    step();
    check("redir_pop_next", 72'(pop_pc_o), 72'(32'h10C));
    step();
    check("redir_drained", 72'(count_o), 72'(0));
    pop_ready_i = 1'b0;

    // flush priority
    push(32'h200, 32'hC0);
    push(32'h204, 32'hC1);
    push(32'h208, 32'hC2);
    push_pc_i    = 32'h20C;
    push_instr_i = 32'hC3;
    flush_i      = 1'b1;
    redirect_i   = 1'b1;
    #1;
    check("flush_ready", 72'(push_ready_o), 72'(0));
    step();
    flush_i      = 1'b0;
    redirect_i   = 1'b0;
    push_valid_i = 1'b0;
    #1;
    check("flush_count", 72'(count_o), 72'(0));
    check("flush_valid", 72'(pop_valid_o), 72'(0));
    check("flush_instr", 72'(pop_instr_o), 72'(0));

    // random traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      push_valid_i  = ($urandom_range(0, 3) != 0);
      pop_ready_i   = ($urandom_range(0, 2) == 0);
      flush_i       = ($urandom_range(0, 31) == 0);
      redirect_i    = ($urandom_range(0, 15) == 0);
      push_pc_i     = 32'h1000 + 32'(i * 4);
      push_instr_i  = $urandom;
      push_except_i = 8'($urandom);
      step();
    end
    flush_i = 1'b0;
    redirect_i = 1'b0;
    push_valid_i = 1'b0;
    pop_ready_i = 1'b1;
    repeat (6) step();
    pop_ready_i = 1'b0;
    check("rand_drained", 72'(count_o), 72'(0));

    // async reset mid-stream
    push(32'h300, 32'hD0);
    push(32'h304, 32'hD1);
    push_valid_i = 1'b0;
    check("arst_pre_count", 72'(count_o), 72'(2));
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", 72'(pop_valid_o), 72'(0));
    check("arst_count", 72'(count_o), 72'(0));
    check("arst_data", {pop_pc_o, pop_instr_o, pop_except_o}, 72'(0));
    repeat (2) step();
    rst = 1'b1;
    step();
    check("arst_release_count", 72'(count_o), 72'(0));
    check("arst_release_ready", 72'(push_ready_o), 72'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
